// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// The state encoding is fixed at 2 bits; encoding 3 is illegal and recovers to IDLE.
package serial_adder_ctrl_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

    // Signed overflow: carry into the sign bit disagrees with carry out of it.
    function automatic logic signed_ovf(input logic cin_msb, input logic cout_msb);
        return cin_msb ^ cout_msb;
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a requester and the serial adder controller.
// Handshake: start is a request sampled only while the controller is idle (busy=0,
// done=0); busy is high for the whole addition and done pulses for one cycle when
// sum/c_out/ovf are valid. Results then hold until the next accepted start.
interface serial_adder_ctrl_if #(
    parameter int W = 8
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;

    modport master (
        output start, a, b, c_in,
        input  busy, done, sum, c_out, ovf
    );

    modport slave (
        input  start, a, b, c_in,
        output busy, done, sum, c_out, ovf
    );
endinterface

// File: rtl/serial_adder_ctrl_full_adder.sv
// The existing 1-bit full adder cell that the controller time-shares.
module full_adder_1 (
    input  logic a,
    input  logic b,
    input  logic c_i,
    output logic c_o,
    output logic s
);
    assign s   = a ^ b ^ c_i;
    assign c_o = (a & b) | (a & c_i) | (b & c_i);
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: captures two W-bit operands and a carry-in, then adds
// one bit per clock LSB first through a single full_adder_1, reporting sum/carry/overflow.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_adder_ctrl_if.slave    bus,
    output state_t                state_dbg
);

    state_t         state;
    state_t         state_nxt;

    logic [CW-1:0]  idx;
    logic [W-1:0]   a_sr;
    logic [W-1:0]   b_sr;
    logic [W-1:0]   sum_r;
    logic           carry;
    logic           cin_msb;
    logic           c_out_r;
    logic           ovf_r;

    logic           load;
    logic           step;
    logic           last;
    logic           fa_s;
    logic           fa_co;

    full_adder_1 u_fa (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .c_i (carry),
        .c_o (fa_co),
        .s   (fa_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (idx == CW'(W - 1)) begin
                    last      = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: operands shift out LSB first while sum bits enter from the MSB side,
    // so after W steps sum_r holds the result in natural bit order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            a_sr    <= '0;
            b_sr    <= '0;
            sum_r   <= '0;
            carry   <= 1'b0;
            cin_msb <= 1'b0;
            c_out_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (load) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            carry <= bus.c_in;
            idx   <= '0;
        end else if (step) begin
            a_sr  <= {1'b0, a_sr[W-1:1]};
            b_sr  <= {1'b0, b_sr[W-1:1]};
            sum_r <= {fa_s, sum_r[W-1:1]};
            carry <= fa_co;
            idx   <= idx + 1'b1;
            if (idx == CW'(W - 2)) begin
                cin_msb <= fa_co;
            end
            if (last) begin
                c_out_r <= fa_co;
                ovf_r   <= signed_ovf(cin_msb, fa_co);
            end
        end
    end

    assign bus.busy  = (state == ST_RUN);
    assign bus.done  = (state == ST_DONE);
    assign bus.sum   = sum_r;
    assign bus.c_out = c_out_r;
    assign bus.ovf   = ovf_r;
    assign state_dbg = state;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: vector table, scoreboard, corner sequences.
module tb_serial_adder_ctrl;
    import serial_adder_ctrl_pkg::*;

    localparam int W  = 8;
    localparam int CW = 5;

    logic   clk;
    logic   rst_n;
    state_t state_dbg;

    serial_adder_ctrl_if #(.W(W)) bus ();

    serial_adder_ctrl #(.W(W), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model, independent of the bit-serial structure: {ovf, c_out, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                                           input logic c_v);
        logic [W:0] t;
        logic       ov;
        t  = {1'b0, a_v} + {1'b0, b_v} + {{W{1'b0}}, c_v};
        ov = (a_v[W-1] == b_v[W-1]) && (t[W-1] != a_v[W-1]);
        return {ov, t};
    endfunction

    // ---------------- scoreboard ----------------
    logic [W+1:0] exp_q[$];
    int           done_cyc_q[$];
    int           n_done    = 0;
    logic         prev_done = 1'b0;

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            logic [W+1:0] e;
            n_done++;
            done_cyc_q.push_back(cyc);
            check("done_single_cycle", {31'd0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sum", {{(32-W){1'b0}}, bus.sum}, {{(32-W){1'b0}}, e[W-1:0]});
                check("c_out", {31'd0, bus.c_out}, {31'd0, e[W]});
                check("ovf", {31'd0, bus.ovf}, {31'd0, e[W+1]});
            end
        end
        prev_done = rst_n ? bus.done : 1'b0;
    end

    // ---------------- driver tasks ----------------
    // Issue one addition from IDLE, verify latency and the return to IDLE.
    task automatic run_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input logic c_v,
                          input logic [W+1:0] exp_v);
        int n;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a_v;
        bus.b     = b_v;
        bus.c_in  = c_v;
        exp_q.push_back(exp_v);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.c_in  = 1'($urandom_range(0, 1));
        check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
        n = 0;
        while (!bus.done && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency_edges", n, W);
        @(posedge clk);
        #1;
        check("idle_after_done", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_done"}, {31'd0, bus.done}, 32'd0);
        check({tag, "_sum"}, {{(32-W){1'b0}}, bus.sum}, 32'd0);
        check({tag, "_c_out"}, {31'd0, bus.c_out}, 32'd0);
        check({tag, "_ovf"}, {31'd0, bus.ovf}, 32'd0);
        check({tag, "_state"}, {30'd0, state_dbg}, {30'd0, ST_IDLE});
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
    } vec_t;

    localparam int NV = 9;
    vec_t tbl[NV];

    initial begin
        int n_before;
        int n;

        tbl[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        for (int i = 5; i < NV; i++) begin
            logic [W+1:0] m;
            tbl[i].a  = W'($urandom);
            tbl[i].b  = W'($urandom);
            tbl[i].c  = 1'($urandom_range(0, 1));
            m         = model(tbl[i].a, tbl[i].b, tbl[i].c);
            tbl[i].es = m[W-1:0];
            tbl[i].ec = m[W];
            tbl[i].eo = m[W+1];
        end

        rst_n     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.c_in  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].c, {tbl[i].eo, tbl[i].ec, tbl[i].es});
        end

        // start during RUN and during DONE must be ignored.
        n_before = n_done;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h12;
        bus.b     = 8'h34;
        bus.c_in  = 1'b0;
        exp_q.push_back({1'b0, 1'b0, 8'h46});
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
        bus.c_in  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busy_ignores_start", {31'd0, bus.busy}, 32'd1);
        n = 0;
        while (!bus.done && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ignored_run_done_seen", {31'd0, bus.done}, 32'd1);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("done_ignores_start", {30'd0, state_dbg}, {30'd0, ST_IDLE});
        repeat (3) @(posedge clk);
        #1;
        check("no_extra_run", {31'd0, bus.busy}, 32'd0);
        check("one_done_only", n_done - n_before, 1);

        // Back-to-back: start held for 3*(W+2) edges.
        done_cyc_q.delete();
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h3C;
        bus.b     = 8'h5A;
        bus.c_in  = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(model(8'h3C, 8'h5A, 1'b1));
        repeat (3 * (W + 2)) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (W + 4) @(posedge clk);
        #1;
        check("b2b_done_count", done_cyc_q.size(), 3);
        if (done_cyc_q.size() >= 3) begin
            check("b2b_gap1", done_cyc_q[1] - done_cyc_q[0], W + 2);
            check("b2b_gap2", done_cyc_q[2] - done_cyc_q[1], W + 2);
        end

        // Asynchronous reset in the middle of RUN.
        n_before = n_done;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'hF0;
        bus.b     = 8'h0F;
        bus.c_in  = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrun_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 3) @(posedge clk);
        #1;
        check("no_done_after_reset", n_done - n_before, 0);

        run_op(8'h01, 8'h02, 1'b1, {1'b0, 1'b0, 8'h04});

        repeat (2) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
